// File: rtl/rshift_multicycle.sv
// rtl/rshift_multicycle.sv - multi-cycle 32-bit logical/arithmetic right shifter
// Applies one barrel level per clock (16, 8, 4, 2, 1) and pulses done with a registered result.
module rshift_multicycle (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [4:0]  sham,
  input  logic        arith,
  output logic        ready,
  output logic        done,
  output logic [31:0] out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nx;
  logic [31:0] work, work_nx;
  logic [4:0]  amt;
  logic        sgn;
  logic [2:0]  stage;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = BUSY;
      BUSY:    if (stage == 3'd4) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One barrel level per stage; the control bit walks amt from MSB to LSB.
  always_comb begin
    work_nx = work;
    case (stage)
      3'd0: if (amt[4]) work_nx = {{16{sgn}}, work[31:16]};
      3'd1: if (amt[3]) work_nx = {{8{sgn}},  work[31:8]};
      3'd2: if (amt[2]) work_nx = {{4{sgn}},  work[31:4]};
      3'd3: if (amt[1]) work_nx = {{2{sgn}},  work[31:2]};
      3'd4: if (amt[0]) work_nx = {sgn,       work[31:1]};
      default: work_nx = work;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      work  <= 32'h0;
      amt   <= 5'h0;
      sgn   <= 1'b0;
      stage <= 3'd0;
      out   <= 32'h0;
    end else begin
      if (state == IDLE && start) begin
        work  <= A;
        amt   <= sham;
        sgn   <= arith & A[31];
        stage <= 3'd0;
      end else if (state == BUSY) begin
        work  <= work_nx;
        stage <= stage + 3'd1;
        if (stage == 3'd4) out <= work_nx;
      end
    end
  end

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

endmodule
